// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern engine: blink, rotate left/right and bounce,
// stepped once every DIV enabled clock cycles, reseeded on every mode change.
module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [1:0]       SW,
  output logic [WIDTH-1:0] LED,
  output logic             Tick,
  output logic             Dir
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'b00,
    MODE_ROL    = 2'b01,
    MODE_ROR    = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  mode_e            mode;
  mode_e            sw_q;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] led_nxt;
  logic             tick_nxt, dir_nxt;

  assign mode = mode_e'(SW);

  function automatic logic [WIDTH-1:0] seed(input mode_e m);
    logic [WIDTH-1:0] s;
    s = '0;
    case (m)
      MODE_ROL, MODE_BOUNCE: s[0]       = 1'b1;
      MODE_ROR:              s[WIDTH-1] = 1'b1;
      default:               s          = '0;
    endcase
    return s;
  endfunction

  // Plain shifts fill with zero; rotations wrap the outgoing bit around.
  function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] v);
    return {1'b0, v[WIDTH-1:1]};
  endfunction

  always_comb begin
    cnt_nxt  = cnt;
    led_nxt  = LED;
    dir_nxt  = Dir;
    tick_nxt = 1'b0;
    if (mode != sw_q) begin
      // Reseed outranks any step landing on the same edge, even when paused.
      led_nxt = seed(mode);
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end else if (En) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
        case (mode)
          MODE_BLINK: led_nxt = ~LED;
          MODE_ROL:   led_nxt = {LED[WIDTH-2:0], LED[WIDTH-1]};
          MODE_ROR:   led_nxt = {LED[0], LED[WIDTH-1:1]};
          default: begin
            // Turn around on the step that leaves an endpoint, so each end dwells one step.
            if (!Dir) begin
              if (LED[WIDTH-1]) begin
                dir_nxt = 1'b1;
                led_nxt = shr(LED);
              end else begin
                led_nxt = shl(LED);
              end
            end else begin
              if (LED[0]) begin
                dir_nxt = 1'b0;
                led_nxt = shl(LED);
              end else begin
                led_nxt = shr(LED);
              end
            end
          end
        endcase
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sw_q <= MODE_BLINK;
      cnt  <= '0;
      LED  <= '0;
      Tick <= 1'b0;
      Dir  <= 1'b0;
    end else begin
      sw_q <= mode;
      cnt  <= cnt_nxt;
      LED  <= led_nxt;
      Tick <= tick_nxt;
      Dir  <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: default 8-LED/DIV=4 instance plus a
// 4-LED/DIV=1 instance for the parameter sweep.
module tb_led_pattern_gen;

  logic       Clk = 1'b0;
  logic       Rst, En;
  logic [1:0] SW;
  logic [7:0] LED;
  logic       Tick, Dir;

  logic       r4, en4;
  logic [1:0] sw4;
  logic [3:0] led4;
  logic       tick4, dir4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  led_pattern_gen #(.WIDTH(8), .DIV(4)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .SW(SW),
    .LED(LED), .Tick(Tick), .Dir(Dir)
  );

  led_pattern_gen #(.WIDTH(4), .DIV(1)) dut4 (
    .Clk(Clk), .Rst(r4), .En(en4), .SW(sw4),
    .LED(led4), .Tick(tick4), .Dir(dir4)
  );

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; En = 1'b1; SW = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++;
      if (LED !== 8'h00 || Dir !== 1'b0 || Tick !== 1'b0) begin
        n_err++;
        $display("FAIL reset: LED=%h Dir=%b Tick=%b, expected 00/0/0", LED, Dir, Tick);
      end
    end
    Rst = 1'b0;
  endtask

  task automatic test_blink();
    logic [7:0] prev, expv;
    prev = 8'h00;
    for (int s = 0; s < 3; s++) begin
      for (int c = 1; c <= 4; c++) begin
        cyc();
        expv = (c == 4) ? ~prev : prev;
        n_cmp++;
        if (LED !== expv || Tick !== (c == 4) || Dir !== 1'b0) begin
          n_err++;
          $display("FAIL blink step%0d cyc%0d: LED=%h Tick=%b Dir=%b, expected %h/%b/0",
                   s, c, LED, Tick, Dir, expv, (c == 4));
        end
      end
      prev = expv;
    end
  endtask

  task automatic test_rotate(input logic [1:0] mode, input logic [7:0] sd);
    logic [7:0] prev, expv;
    SW = mode;
    cyc();
    n_cmp++;
    if (LED !== sd || Tick !== 1'b0) begin
      n_err++;
      $display("FAIL rot%0d seed: LED=%h Tick=%b, expected %h/0", mode, LED, Tick, sd);
    end
    prev = sd;
    for (int s = 0; s < 8; s++) begin
      for (int c = 1; c <= 4; c++) begin
        cyc();
        if (c == 4)
          expv = (mode == 2'b01) ? {prev[6:0], prev[7]} : {prev[0], prev[7:1]};
        else
          expv = prev;
        n_cmp++;
        if (LED !== expv || Tick !== (c == 4) || Dir !== 1'b0) begin
          n_err++;
          $display("FAIL rot%0d step%0d cyc%0d: LED=%h Tick=%b Dir=%b, expected %h/%b/0",
                   mode, s, c, LED, Tick, Dir, expv, (c == 4));
        end
      end
      prev = expv;
    end
  endtask

  task automatic test_bounce();
    logic [7:0] seq [15];
    logic       dsq [15];
    logic [7:0] prev, expv;
    logic       pdir, expd;
    seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    dsq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    SW = 2'b11;
    cyc();
    n_cmp++;
    if (LED !== 8'h01 || Dir !== 1'b0 || Tick !== 1'b0) begin
      n_err++;
      $display("FAIL bounce seed: LED=%h Dir=%b Tick=%b, expected 01/0/0", LED, Dir, Tick);
    end
    prev = 8'h01; pdir = 1'b0;
    for (int s = 0; s < 15; s++) begin
      for (int c = 1; c <= 4; c++) begin
        cyc();
        expv = (c == 4) ? seq[s] : prev;
        expd = (c == 4) ? dsq[s] : pdir;
        n_cmp++;
        if (LED !== expv || Dir !== expd || Tick !== (c == 4)) begin
          n_err++;
          $display("FAIL bounce step%0d cyc%0d: LED=%h Dir=%b Tick=%b, expected %h/%b/%b",
                   s, c, LED, Dir, Tick, expv, expd, (c == 4));
        end
      end
      prev = expv; pdir = expd;
    end
  endtask

  task automatic test_pause_priority();
    // Bring mode 01 to LED=04 with one count already accumulated.
    SW = 2'b01;
    for (int i = 0; i < 10; i++) cyc();
    n_cmp++;
    if (LED !== 8'h04) begin
      n_err++;
      $display("FAIL pause setup: LED=%h, expected 04", LED);
    end
    En = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++;
      if (LED !== 8'h04 || Tick !== 1'b0 || Dir !== 1'b0) begin
        n_err++;
        $display("FAIL pause hold cyc%0d: LED=%h Tick=%b Dir=%b, expected 04/0/0", i, LED, Tick, Dir);
      end
    end
    En = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      n_cmp++;
      if (LED !== ((c == 3) ? 8'h08 : 8'h04) || Tick !== (c == 3)) begin
        n_err++;
        $display("FAIL pause resume cyc%0d: LED=%h Tick=%b, expected %h/%b",
                 c, LED, Tick, (c == 3) ? 8'h08 : 8'h04, (c == 3));
      end
    end
    // Mode change while paused still reseeds.
    En = 1'b0; SW = 2'b10;
    cyc();
    n_cmp++;
    if (LED !== 8'h80 || Tick !== 1'b0) begin
      n_err++;
      $display("FAIL paused reseed: LED=%h Tick=%b, expected 80/0", LED, Tick);
    end
    for (int i = 0; i < 3; i++) cyc();
    n_cmp++;
    if (LED !== 8'h80) begin
      n_err++;
      $display("FAIL paused hold after reseed: LED=%h, expected 80", LED);
    end
    En = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      n_cmp++;
      if (LED !== ((c == 4) ? 8'h40 : 8'h80) || Tick !== (c == 4)) begin
        n_err++;
        $display("FAIL reseed first step cyc%0d: LED=%h Tick=%b, expected %h/%b",
                 c, LED, Tick, (c == 4) ? 8'h40 : 8'h80, (c == 4));
      end
    end
    // Three more edges put cnt at 3; the mode change then lands on the step edge.
    for (int i = 0; i < 3; i++) cyc();
    SW = 2'b01;
    cyc();
    n_cmp++;
    if (LED !== 8'h01 || Tick !== 1'b0) begin
      n_err++;
      $display("FAIL seed vs step: LED=%h Tick=%b, expected 01/0", LED, Tick);
    end
    for (int c = 1; c <= 4; c++) begin
      cyc();
      n_cmp++;
      if (LED !== ((c == 4) ? 8'h02 : 8'h01) || Tick !== (c == 4)) begin
        n_err++;
        $display("FAIL post-priority cyc%0d: LED=%h Tick=%b, expected %h/%b",
                 c, LED, Tick, (c == 4) ? 8'h02 : 8'h01, (c == 4));
      end
    end
  endtask

  task automatic test_reset_mid_bounce();
    SW = 2'b11;
    cyc();
    for (int i = 0; i < 32; i++) cyc();
    n_cmp++;
    if (LED !== 8'h40 || Dir !== 1'b1) begin
      n_err++;
      $display("FAIL bounce pre-reset: LED=%h Dir=%b, expected 40/1", LED, Dir);
    end
    for (int i = 0; i < 3; i++) cyc();
    Rst = 1'b1;
    cyc();
    n_cmp++;
    if (LED !== 8'h00 || Dir !== 1'b0 || Tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset mid-bounce: LED=%h Dir=%b Tick=%b, expected 00/0/0", LED, Dir, Tick);
    end
    Rst = 1'b0;
    // Registered mode restarts at 00, so SW=11 reseeds on the first free edge.
    cyc();
    n_cmp++;
    if (LED !== 8'h01 || Tick !== 1'b0) begin
      n_err++;
      $display("FAIL reseed after reset: LED=%h Tick=%b, expected 01/0", LED, Tick);
    end
    for (int c = 1; c <= 4; c++) begin
      cyc();
      n_cmp++;
      if (LED !== ((c == 4) ? 8'h02 : 8'h01) || Tick !== (c == 4)) begin
        n_err++;
        $display("FAIL after reset cyc%0d: LED=%h Tick=%b, expected %h/%b",
                 c, LED, Tick, (c == 4) ? 8'h02 : 8'h01, (c == 4));
      end
    end
  endtask

  task automatic test_width4_div1();
    logic [3:0] seq [7];
    logic       dsq [7];
    seq = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    dsq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    r4 = 1'b1; en4 = 1'b1; sw4 = 2'b00;
    cyc();
    n_cmp++;
    if (led4 !== 4'h0 || tick4 !== 1'b0 || dir4 !== 1'b0) begin
      n_err++;
      $display("FAIL w4 reset: LED=%h Tick=%b Dir=%b, expected 0/0/0", led4, tick4, dir4);
    end
    r4 = 1'b0; sw4 = 2'b11;
    cyc();
    n_cmp++;
    if (led4 !== 4'h1 || tick4 !== 1'b0) begin
      n_err++;
      $display("FAIL w4 seed: LED=%h Tick=%b, expected 1/0", led4, tick4);
    end
    for (int s = 0; s < 7; s++) begin
      cyc();
      n_cmp++;
      if (led4 !== seq[s] || tick4 !== 1'b1 || dir4 !== dsq[s]) begin
        n_err++;
        $display("FAIL w4 step%0d: LED=%h Tick=%b Dir=%b, expected %h/1/%b",
                 s, led4, tick4, dir4, seq[s], dsq[s]);
      end
    end
  endtask

  initial begin
    Rst = 1'b1; En = 1'b1; SW = 2'b00;
    r4 = 1'b1; en4 = 1'b1; sw4 = 2'b00;
    test_reset();
    test_blink();
    test_rotate(2'b01, 8'h01);
    test_rotate(2'b10, 8'h80);
    test_bounce();
    test_pause_priority();
    test_reset_mid_bounce();
    test_width4_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised LED pattern engine for the board-level switch/LED exercises. It generalises the fixed 8-LED, 2-switch controller.
- WIDTH LEDs are driven by a 2-bit mode select (SW) and stepped at a programmable prescaled rate.
- Four modes: blink, rotate left, rotate right, bounce.
- Adds pause (En), automatic reseed on mode change, and observable Tick/Dir status.

Parameters:
- WIDTH, 8, number of LEDs; legal range 2..32.
- DIV, 4, Clk cycles per pattern step; legal range 1..2^24. Counter width CW = max(1, $clog2(DIV)).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- En  input  1  step enable; 0 pauses prescaler and pattern.
- SW  input  2  mode select: 00 blink, 01 rotate left, 10 rotate right, 11 bounce.
- LED  output  WIDTH  registered pattern.
- Tick  output  1  registered; high for exactly the one cycle in which LED shows a newly stepped value.
- Dir  output  1  registered bounce direction: 0 = toward MSB, 1 = toward LSB; 0 in all non-bounce modes.

Behaviour:
- Reset (Rst=1 at an edge), overriding everything: LED=0, Tick=0, Dir=0, prescaler cnt=0, registered mode SW_q=2'b00.
- Reset mid-operation discards all state. There is no partial step.
- SW_q <= SW every edge.
- Mode change: SW != SW_q at an edge (combinational compare). At that edge:
  - LED <= seed(SW), cnt <= 0, Dir <= 0, Tick <= 0.
  - Consequence: LED shows the seed one cycle after SW changes.
  - Takes priority over a coincident step. Applies even when En=0.
- Seeds:
  - blink = all zeros
  - rotate left = 1 (bit 0)
  - rotate right = bit WIDTH-1
  - bounce = 1 (bit 0)
- Prescaler, when no reset and no mode change:
  - En=1: cnt increments. When cnt==DIV-1, cnt <= 0 and a step occurs.
  - En=0: cnt, LED and Dir hold; Tick <= 0.
  - DIV=1: step every enabled cycle.
- Step actions:
  - 00 blink: LED <= ~LED (all-zeros <-> all-ones).
  - 01 rotate left: LED <= {LED[WIDTH-2:0], LED[WIDTH-1]}.
  - 10 rotate right: LED <= {LED[0], LED[WIDTH-1:1]}.
  - 11 bounce, Dir=0: if LED[WIDTH-1]=1, then Dir <= 1 and LED shifts right; else LED shifts left.
  - 11 bounce, Dir=1: if LED[0]=1, then Dir <= 0 and LED shifts left; else LED shifts right.
  - Bounce endpoints are therefore each shown for one step only (no double dwell).
- Tick: Tick <= 1 on an edge where a step occurs, else 0. With En=1 steady, Tick pulses once every DIV cycles.
- Steady-state step period is exactly DIV cycles. The first step after a reseed or reset occurs DIV enabled cycles later.
- Non-seed LED contents (e.g. forced by a mis-sequenced mode) are still rotated or shifted as defined. Shifts fill with 0. No lockup handling is required beyond a reseed on the next mode change.

Test Plan:
- Defaults (WIDTH=8, DIV=4). Assert Rst 2 cycles with SW=00, En=1, then release. Required: LED=00, Dir=0, Tick=0 during reset. After release, LED goes 00->FF->00 every 4 cycles, with Tick high in each cycle LED changes.
- SW 00->01. Required: LED=01 one cycle later. Then 02, 04, ..., 80, 01 every 4 cycles, with wrap from 80 to 01.
- SW ->10. Required: LED=80 next cycle. Then 40, 20, ..., 01, 80 every 4 cycles.
- SW ->11. Required: LED 01, 02, ..., 80, 40, ..., 01, 02. Dir goes 1 on the step leaving 80 and returns to 0 on the step leaving 01.
- Pause and priority:
  - In mode 01 at LED=04, drop En for 10 cycles. Required: LED, cnt and Dir frozen; Tick=0.
  - Change SW to 10 while En=0. Required: LED=80 next cycle.
  - Change SW exactly in a cycle with cnt==3. Required: seed wins, no Tick that cycle, next step 4 enabled cycles later.
  - Assert Rst mid-bounce. Required: all outputs 0 next cycle.
- Parameter sweep: WIDTH=4, DIV=1, mode 11. Required: LED 1, 2, 4, 8, 4, 2, 1, 2 on consecutive cycles, Tick high every cycle.
